uart_tx_mmio_responder: RTL and testbench



---
 rtl/uart_tx_mmio_responder_pkg.sv | 36 +++
 rtl/uart_tx_mmio_responder_if.sv | 14 +
 rtl/uart_tx_mmio_responder_fifo.sv | 56 +++++
 rtl/uart_tx_mmio_responder.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_mmio_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_responder_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register word indices, STATUS/CTRL bit positions and the FSM state encoding.
package uart_tx_mmio_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Register word indices inside the 5-word UART window
    localparam int unsigned REG_TXDATA = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_BAUD   = 2;
    localparam int unsigned REG_CTRL   = 3;
    localparam int unsigned REG_TXCNT  = 4;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;
    localparam int unsigned STAT_CNT_LSB   = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_TXEN_BIT  = 0;
    localparam int unsigned CTRL_IRQEN_BIT = 1;
    localparam int unsigned CTRL_CLR_BIT   = 2;
    localparam int unsigned CTRL_PODD_BIT  = 3;

    // S_PARITY is only reachable when the parity feature is compiled in
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_mmio_responder_if.sv
// Decoder-side register bus for the UART: select/write/word-index/write-data
// from the decoder, combinational read data back.
interface uart_tx_mmio_responder_if #(
    parameter int ADDR_W = 3
);
    logic              select;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output select, output write, output addr, output wdata, input rdata);
    modport slave  (input select, input write, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_mmio_responder_fifo.sv
// Byte-wide synchronous TX FIFO. Depth must be a power of two so the
// pointers wrap naturally. A push when full is dropped; clr empties it.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clr behaves like a reset of the queue
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio_responder.sv
// Memory-mapped 8N1 UART transmitter on the decoder's device-3 port.
// Registers: TX_DATA, STATUS, BAUD_DIV, CTRL, TX_COUNT at word indices 0-4.
// Optional even/odd parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_mmio_responder
    import uart_tx_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DIV_RST = 16'd433,
    parameter int          ADDR_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_mmio_responder_if.slave       bus,
    output logic                          tx,
    output logic                          irq
);
    localparam int IDX_W = $clog2(DATA_BITS);

    state_t                     state, next_state;
    logic [15:0]                baud_div;
    logic [15:0]                div_q;
    logic [15:0]                bit_cnt;
    logic [IDX_W-1:0]           bit_idx;
    logic [DATA_BITS-1:0]       data_q;
    logic                       tx_en, irq_en, parity_odd, overflow;
    logic [31:0]                tx_count;
    logic                       fifo_pop, fifo_full, fifo_empty, fifo_clr;
    logic [7:0]                 fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       reg_wr, wr_txdata, wr_status, wr_baud, wr_ctrl, wr_txcnt;
    logic                       bit_tick, frame_done, parity_bit;
    logic [31:0]                rd_val, status_rd, ctrl_rd;
    logic                       unused_wdata;

    assign unused_wdata = ^bus.wdata[31:16];

    assign reg_wr    = bus.select && bus.write;
    assign wr_txdata = reg_wr && (bus.addr == ADDR_W'(REG_TXDATA));
    assign wr_status = reg_wr && (bus.addr == ADDR_W'(REG_STATUS));
    assign wr_baud   = reg_wr && (bus.addr == ADDR_W'(REG_BAUD));
    assign wr_ctrl   = reg_wr && (bus.addr == ADDR_W'(REG_CTRL));
    assign wr_txcnt  = reg_wr && (bus.addr == ADDR_W'(REG_TXCNT));
    assign fifo_clr  = wr_ctrl && bus.wdata[CTRL_CLR_BIT];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Software-visible configuration and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_div <= BAUD_DIV_RST;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            tx_count <= '0;
        end else begin
            if (wr_baud) baud_div <= bus.wdata[15:0];
            if (wr_ctrl) begin
                tx_en  <= bus.wdata[CTRL_TXEN_BIT];
                irq_en <= bus.wdata[CTRL_IRQEN_BIT];
            end
            // A new overflow event takes priority over a same-cycle W1C
            if (wr_txdata && fifo_full)                     overflow <= 1'b1;
            else if (wr_status && bus.wdata[STAT_OVF_BIT])  overflow <= 1'b0;
            // Software clear beats a same-cycle frame completion
            if (wr_txcnt)        tx_count <= '0;
            else if (frame_done) tx_count <= tx_count + 32'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity sense selection, only present with the parity feature
    always_ff @(posedge clk) begin
        if (!rst_n)       parity_odd <= 1'b0;
        else if (wr_ctrl) parity_odd <= bus.wdata[CTRL_PODD_BIT];
    end
`else
    assign parity_odd = 1'b0;
`endif

    assign parity_bit = (^data_q) ^ parity_odd;
    assign bit_tick   = (bit_cnt == 16'd0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // FSM next state, FIFO pop, frame completion and serial line level
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state = state;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        tx         = 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    next_state = S_START;
                    fifo_pop   = 1'b1;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_tick) next_state = S_DATA;
            end
            S_DATA: begin
                tx = data_q[bit_idx];
                if (bit_tick && bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                tx = parity_bit;
                if (bit_tick) next_state = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) begin
                    frame_done = 1'b1;
                    if (tx_en && !fifo_empty) begin
                        next_state = S_START;
                        fifo_pop   = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Frame datapath: byte capture, bit-time down-counter and bit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            div_q   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (fifo_pop) begin
            data_q  <= fifo_dout;
            div_q   <= baud_div;
            bit_cnt <= baud_div;
            bit_idx <= '0;
        end else if (state != S_IDLE) begin
            if (bit_tick) begin
                bit_cnt <= div_q;
                if (state == S_DATA) bit_idx <= bit_idx + IDX_W'(1);
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

    assign irq = fifo_empty && (state == S_IDLE) && irq_en;

    // Combinational read mux; reads have no side effects
    always_comb begin
        status_rd                          = '0;
        status_rd[STAT_BUSY_BIT]           = (state != S_IDLE);
        status_rd[STAT_FULL_BIT]           = fifo_full;
        status_rd[STAT_EMPTY_BIT]          = fifo_empty;
        status_rd[STAT_OVF_BIT]            = overflow;
        status_rd[STAT_CNT_LSB +: 3]       = 3'(fifo_count);
        ctrl_rd                            = '0;
        ctrl_rd[CTRL_TXEN_BIT]             = tx_en;
        ctrl_rd[CTRL_IRQEN_BIT]            = irq_en;
        ctrl_rd[CTRL_PODD_BIT]             = parity_odd;
        rd_val                             = '0;
        if (bus.select) begin
            case (bus.addr)
                ADDR_W'(REG_STATUS): rd_val = status_rd;
                ADDR_W'(REG_BAUD):   rd_val = {16'h0, baud_div};
                ADDR_W'(REG_CTRL):   rd_val = ctrl_rd;
                ADDR_W'(REG_TXCNT):  rd_val = tx_count;
                default:             rd_val = '0;
            endcase
        end
    end

    assign bus.rdata = rd_val;

endmodule

// File: tb/tb_uart_tx_mmio_responder.sv
// Directed bench for uart_tx_mmio_responder: a register-access vector table
// followed by hand-written serial-frame, FIFO, reset and enable sequences.
module tb_uart_tx_mmio_responder;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] CTRL_EXP = 32'h0000_000A;
`else
    localparam logic [31:0] CTRL_EXP = 32'h0000_0002;
`endif
    localparam int NV = 19;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    logic tx;
    logic irq;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    uart_tx_mmio_responder_if #(.ADDR_W(3)) bus ();

    uart_tx_mmio_responder #(
        .FIFO_DEPTH   (4),
        .BAUD_DIV_RST (16'd433),
        .ADDR_W       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic sel, input logic wr, input logic [2:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp, input string name);
        vec_t v;
        v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.select = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.select = 1'b0; bus.write = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        @(negedge clk);
        bus.select = 1'b1; bus.write = 1'b0; bus.addr = a;
        #1 d = bus.rdata;
        bus.select = 1'b0;
        check(name, d, exp);
    endtask

    // Leaves the caller on the negedge where tx is first seen low
    task automatic wait_tx_low(input int max_cycles, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Samples every cycle of nframes back-to-back frames, starting at the current negedge
    task automatic capture_frames(input int nframes, input int div, input logic [31:0] bytes_in,
                                  input string tag);
        logic [9:0] exp_f;
        logic [9:0] got;
        int         unstable;
        for (int f = 0; f < nframes; f++) begin
            exp_f    = {1'b1, bytes_in[8*f +: 8], 1'b0};
            got      = '0;
            unstable = 0;
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s <= div; s++) begin
                    if (!(f == 0 && b == 0 && s == 0)) @(negedge clk);
                    if (s == 0) got[b] = tx;
                    else if (tx !== got[b]) unstable++;
                end
            end
            check($sformatf("%s_frame%0d", tag, f), 32'(got), 32'(exp_f));
            check($sformatf("%s_stable%0d", tag, f), 32'(unstable), 32'd0);
        end
    endtask

    initial begin
        int          lows;
        logic        done;
        checks = 0;
        errors = 0;
        bus.select = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;

        vecs[0]  = mk(1, 0, 3'd1, 32'h0, 32'h0000_0004, "status_rst");
        vecs[1]  = mk(1, 0, 3'd2, 32'h0, 32'd433,       "baud_rst");
        vecs[2]  = mk(1, 0, 3'd3, 32'h0, 32'h0,         "ctrl_rst");
        vecs[3]  = mk(1, 0, 3'd4, 32'h0, 32'h0,         "txcnt_rst");
        vecs[4]  = mk(1, 0, 3'd0, 32'h0, 32'h0,         "txdata_rd");
        vecs[5]  = mk(1, 0, 3'd6, 32'h0, 32'h0,         "idx6_rd");
        vecs[6]  = mk(0, 0, 3'd2, 32'h0, 32'h0,         "nosel_rd");
        vecs[7]  = mk(1, 1, 3'd2, 32'hABCD_1234, 32'h0, "baud_wr_op");
        vecs[8]  = mk(1, 0, 3'd2, 32'h0, 32'h0000_1234, "baud_wr");
        vecs[9]  = mk(0, 1, 3'd2, 32'h0000_5555, 32'h0, "baud_nosel_op");
        vecs[10] = mk(1, 0, 3'd2, 32'h0, 32'h0000_1234, "baud_nosel_wr");
        vecs[11] = mk(1, 1, 3'd3, 32'h0000_000E, 32'h0, "ctrl_wr_op");
        vecs[12] = mk(1, 0, 3'd3, 32'h0, CTRL_EXP,      "ctrl_wr");
        vecs[13] = mk(1, 1, 3'd7, 32'hFFFF_FFFF, 32'h0, "idx7_op");
        vecs[14] = mk(1, 0, 3'd2, 32'h0, 32'h0000_1234, "idx7_baud");
        vecs[15] = mk(1, 0, 3'd3, 32'h0, CTRL_EXP,      "idx7_ctrl");
        vecs[16] = mk(1, 0, 3'd1, 32'h0, 32'h0000_0004, "idx7_status");
        vecs[17] = mk(1, 1, 3'd3, 32'h0, 32'h0,         "ctrl_clr_op");
        vecs[18] = mk(1, 0, 3'd3, 32'h0, 32'h0,         "ctrl_zero");

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        // Register access table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.select = vecs[i].sel; bus.write = vecs[i].wr;
            bus.addr   = vecs[i].addr; bus.wdata = vecs[i].wdata;
            #1;
            if (!vecs[i].wr) check(vecs[i].name, bus.rdata, vecs[i].exp);
        end
        @(negedge clk);
        bus.select = 1'b0; bus.write = 1'b0;
        check("idle_tx", 32'(tx), 32'd1);

        // Single 0x55 frame at 4 clocks per bit
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'h55);
        wait_tx_low(20, "a_start");
        capture_frames(1, 3, 32'h55, "a");
        read_check(3'd1, 32'h0000_0004, "a_status_idle");
        read_check(3'd4, 32'd1, "a_txcnt");
        check("a_irq_off", 32'(irq), 32'd0);

        // Overflow with transmitter disabled, then W1C
        bus_write(3'd3, 32'd0);
        for (int k = 0; k < 5; k++) bus_write(3'd0, 32'h11 + 32'(k));
        read_check(3'd1, 32'h0000_004A, "b_status_ovf");
        bus_write(3'd1, 32'h8);
        read_check(3'd1, 32'h0000_0042, "b_status_w1c");

        // fifo_clr, then three back-to-back frames at 1 clock per bit
        bus_write(3'd3, 32'h4);
        read_check(3'd1, 32'h0000_0004, "c_fifo_clr");
        read_check(3'd3, 32'h0, "c_clr_reads0");
        bus_write(3'd0, 32'hA5);
        bus_write(3'd0, 32'h3C);
        bus_write(3'd0, 32'h0F);
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'h3);
        wait_tx_low(20, "c_start");
        capture_frames(3, 0, 32'h000F_3CA5, "c");
        check("c_irq_busy", 32'(irq), 32'd0);
        @(negedge clk);
        check("c_irq_idle", 32'(irq), 32'd1);
        check("c_tx_idle", 32'(tx), 32'd1);
        read_check(3'd4, 32'd4, "c_txcnt");
        bus_write(3'd4, 32'hFFFF);
        read_check(3'd4, 32'd0, "c_txcnt_clr");

        // Reset during the 5th data bit
        bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'd3);
        bus_write(3'd0, 32'h0F);
        bus_write(3'd0, 32'hF0);
        bus_write(3'd3, 32'd1);
        wait_tx_low(20, "d_start");
        repeat (16) @(negedge clk);
        check("d_bit3", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);
        check("d_bit4", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("d_rst_tx", 32'(tx), 32'd1);
        read_check(3'd1, 32'h0000_0004, "d_rst_status");
        read_check(3'd4, 32'd0, "d_rst_txcnt");
        read_check(3'd2, 32'd433, "d_rst_baud");
        rst_n = 1'b1;

        // Clearing tx_en mid-frame finishes that frame and starts no other
        bus_write(3'd2, 32'd1);
        bus_write(3'd0, 32'h81);
        bus_write(3'd0, 32'h7E);
        bus_write(3'd3, 32'd1);
        wait_tx_low(20, "e_start");
        bus_write(3'd3, 32'd0);
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.select = 1'b1; bus.write = 1'b0; bus.addr = 3'd1;
            #1;
            if (bus.rdata[0] == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        bus.select = 1'b0;
        check("e_idle_reached", 32'(done), 32'd1);
        read_check(3'd1, 32'h0000_0010, "e_status");
        read_check(3'd4, 32'd1, "e_txcnt");
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("e_no_new_frame", 32'(lows), 32'd0);
        read_check(3'd1, 32'h0000_0010, "e_status_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
